// File: rtl/avalon_st_enforcer.sv
// Registered Avalon-ST framing enforcer: repairs SOP/EOP framing from an untrusted source
// and flags each violation with a one-cycle error pulse.
module avalon_st_enforcer #(
    parameter int unsigned DATA_WIDTH_IN_BYTES = 16,
    parameter int unsigned MAX_PACKET_BEATS    = 64,
    parameter int unsigned DOUBLE_SOP_INSERT   = 1,
    localparam int unsigned DW = 8 * DATA_WIDTH_IN_BYTES,
    localparam int unsigned EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] untrusted_msg_data_i,
    input  logic          untrusted_msg_valid_i,
    input  logic          untrusted_msg_sop_i,
    input  logic          untrusted_msg_eop_i,
    input  logic [EW-1:0] untrusted_msg_empty_i,
    output logic          untrusted_msg_ready_o,
    output logic [DW-1:0] enforced_msg_data_o,
    output logic          enforced_msg_valid_o,
    output logic          enforced_msg_sop_o,
    output logic          enforced_msg_eop_o,
    output logic [EW-1:0] enforced_msg_empty_o,
    input  logic          enforced_msg_ready_i,
    output logic          missing_sop_error,
    output logic          double_sop_error,
    output logic          oversize_error
);

    localparam int unsigned CW = (MAX_PACKET_BEATS > 0) ? $clog2(MAX_PACKET_BEATS + 1) : 1;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_IN_PKT     = 2'd1;
    localparam logic [1:0] S_INSERT_EOP = 2'd2;
    localparam logic [1:0] S_DISCARD    = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_sop_q, out_sop_d;
    logic          out_eop_q, out_eop_d;
    logic [EW-1:0] out_empty_q, out_empty_d;
    logic          stash_full_q, stash_full_d;
    logic [DW-1:0] stash_data_q, stash_data_d;
    logic          stash_eop_q, stash_eop_d;
    logic [EW-1:0] stash_empty_q, stash_empty_d;
    logic          missing_q, missing_d;
    logic          double_q, double_d;
    logic          oversize_q, oversize_d;

    logic          out_free;
    logic          accept;
    logic [CW-1:0] cnt_inc;
    logic [EW-1:0] in_empty_masked;
    logic          load_in, load_filler, load_stash, force_eop;

    assign out_free              = !out_valid_q || enforced_msg_ready_i;
    assign untrusted_msg_ready_o = out_free && !stash_full_q;
    assign accept                = untrusted_msg_valid_i && untrusted_msg_ready_o;
    assign cnt_inc               = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CW'(1);
    assign in_empty_masked       = untrusted_msg_eop_i ? untrusted_msg_empty_i : '0;

    // Framing FSM plus output-register / stash next-state.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        out_valid_d   = out_valid_q && !enforced_msg_ready_i;
        out_data_d    = out_data_q;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_empty_d   = out_empty_q;
        stash_full_d  = stash_full_q;
        stash_data_d  = stash_data_q;
        stash_eop_d   = stash_eop_q;
        stash_empty_d = stash_empty_q;
        missing_d     = 1'b0;
        double_d      = 1'b0;
        oversize_d    = 1'b0;
        load_in       = 1'b0;
        load_filler   = 1'b0;
        load_stash    = 1'b0;
        force_eop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (untrusted_msg_sop_i) begin
                        load_in = 1'b1;
                        if (!untrusted_msg_eop_i) begin
                            beat_cnt_d = CW'(1);
                            state_d    = S_IN_PKT;
                        end
                    end else begin
                        missing_d = 1'b1;
                    end
                end
            end
            S_IN_PKT: begin
                if (accept) begin
                    if (untrusted_msg_sop_i) begin
                        double_d = 1'b1;
                        if (DOUBLE_SOP_INSERT != 0) begin
                            // Output register is free on accept, so the filler goes out immediately.
                            load_filler   = 1'b1;
                            stash_full_d  = 1'b1;
                            stash_data_d  = untrusted_msg_data_i;
                            stash_eop_d   = untrusted_msg_eop_i;
                            stash_empty_d = in_empty_masked;
                            state_d       = S_INSERT_EOP;
                        end else begin
                            state_d = S_DISCARD;
                        end
                    end else begin
                        load_in    = 1'b1;
                        beat_cnt_d = cnt_inc;
                        if (untrusted_msg_eop_i) begin
                            state_d = S_IDLE;
                        end else if (MAX_PACKET_BEATS != 0 && cnt_inc == CW'(MAX_PACKET_BEATS)) begin
                            force_eop  = 1'b1;
                            oversize_d = 1'b1;
                            state_d    = S_DISCARD;
                        end
                    end
                end
            end
            S_INSERT_EOP: begin
                if (out_free) begin
                    load_stash   = 1'b1;
                    stash_full_d = 1'b0;
                    beat_cnt_d   = stash_eop_q ? '0 : CW'(1);
                    state_d      = stash_eop_q ? S_IDLE : S_IN_PKT;
                end
            end
            S_DISCARD: begin
                if (accept) begin
                    if (untrusted_msg_eop_i) begin
                        state_d = S_IDLE;
                    end else if (untrusted_msg_sop_i) begin
                        double_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load_in) begin
            out_valid_d = 1'b1;
            out_data_d  = untrusted_msg_data_i;
            out_sop_d   = untrusted_msg_sop_i;
            out_eop_d   = untrusted_msg_eop_i || force_eop;
            out_empty_d = in_empty_masked;
        end else if (load_filler) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b1;
            out_empty_d = EW'(DATA_WIDTH_IN_BYTES - 1);
        end else if (load_stash) begin
            out_valid_d = 1'b1;
            out_data_d  = stash_data_q;
            out_sop_d   = 1'b1;
            out_eop_d   = stash_eop_q;
            out_empty_d = stash_empty_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            beat_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_empty_q   <= '0;
            stash_full_q  <= 1'b0;
            stash_data_q  <= '0;
            stash_eop_q   <= 1'b0;
            stash_empty_q <= '0;
            missing_q     <= 1'b0;
            double_q      <= 1'b0;
            oversize_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_empty_q   <= out_empty_d;
            stash_full_q  <= stash_full_d;
            stash_data_q  <= stash_data_d;
            stash_eop_q   <= stash_eop_d;
            stash_empty_q <= stash_empty_d;
            missing_q     <= missing_d;
            double_q      <= double_d;
            oversize_q    <= oversize_d;
        end
    end

    assign enforced_msg_valid_o = out_valid_q;
    assign enforced_msg_data_o  = out_data_q;
    assign enforced_msg_sop_o   = out_sop_q;
    assign enforced_msg_eop_o   = out_eop_q;
    assign enforced_msg_empty_o = out_empty_q;
    assign missing_sop_error    = missing_q;
    assign double_sop_error     = double_q;
    assign oversize_error       = oversize_q;

endmodule

// File: tb/tb_avalon_st_enforcer.sv
// Scoreboard bench for avalon_st_enforcer: packet-level reference model feeds an expected-beat
// queue; a negedge monitor compares output beats, error pulses and stall stability.
module tb_avalon_st_enforcer;

    localparam int unsigned NB   = 16;
    localparam int unsigned DW   = 8 * NB;
    localparam int unsigned EW   = 4;
    localparam int unsigned MAXB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [EW-1:0] in_empty = '0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [EW-1:0] out_empty;
    logic          out_ready = 1'b1;
    logic          err_missing, err_double, err_over;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    bit    m_in_pkt = 0, m_discard = 0;
    int    m_cnt = 0;
    bit    pend_miss = 0, pend_dbl = 0, pend_over = 0;
    bit    stall_prev = 0;
    beat_t stall_beat;
    bit    armed = 0;
    bit    ready_rand = 0;

    avalon_st_enforcer #(
        .DATA_WIDTH_IN_BYTES(NB),
        .MAX_PACKET_BEATS   (MAXB),
        .DOUBLE_SOP_INSERT  (1)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .untrusted_msg_data_i (in_data),
        .untrusted_msg_valid_i(in_valid),
        .untrusted_msg_sop_i  (in_sop),
        .untrusted_msg_eop_i  (in_eop),
        .untrusted_msg_empty_i(in_empty),
        .untrusted_msg_ready_o(in_ready),
        .enforced_msg_data_o  (out_data),
        .enforced_msg_valid_o (out_valid),
        .enforced_msg_sop_o   (out_sop),
        .enforced_msg_eop_o   (out_eop),
        .enforced_msg_empty_o (out_empty),
        .enforced_msg_ready_i (out_ready),
        .missing_sop_error    (err_missing),
        .double_sop_error     (err_double),
        .oversize_error       (err_over)
    );

    always #5 clk = ~clk;

    function automatic void check_bits(input string name, input logic [191:0] act, input logic [191:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    // Reference model: framing rules applied to each accepted input beat.
    function automatic void model_accept(input beat_t b);
        beat_t o;
        beat_t filler;
        o = b;
        if (!b.eop) o.empty = '0;
        filler = '{data: '0, sop: 1'b0, eop: 1'b1, empty: EW'(NB - 1)};
        if (m_discard) begin
            if (b.eop) m_discard = 0;
            else if (b.sop) pend_dbl = 1;
        end else if (!m_in_pkt) begin
            if (b.sop) begin
                exp_q.push_back(o);
                if (!b.eop) begin
                    m_in_pkt = 1;
                    m_cnt    = 1;
                end
            end else begin
                pend_miss = 1;
            end
        end else if (b.sop) begin
            pend_dbl = 1;
            exp_q.push_back(filler);
            exp_q.push_back(o);
            m_in_pkt = !b.eop;
            m_cnt    = 1;
        end else begin
            m_cnt++;
            if (b.eop) begin
                exp_q.push_back(o);
                m_in_pkt = 0;
            end else if (m_cnt == MAXB) begin
                o.eop   = 1'b1;
                o.empty = '0;
                exp_q.push_back(o);
                pend_over = 1;
                m_in_pkt  = 0;
                m_discard = 1;
            end else begin
                exp_q.push_back(o);
            end
        end
    endfunction

    // Monitor: error pulses, stall stability, output beats, then model update from input accepts.
    always @(negedge clk) begin
        beat_t act;
        beat_t e;
        if (rst) armed = 1;
        if (armed) begin
            check_bits("missing_sop_error", 192'(err_missing), 192'(pend_miss));
            check_bits("double_sop_error", 192'(err_double), 192'(pend_dbl));
            check_bits("oversize_error", 192'(err_over), 192'(pend_over));
        end
        pend_miss = 0;
        pend_dbl  = 0;
        pend_over = 0;
        if (rst) begin
            exp_q.delete();
            m_in_pkt   = 0;
            m_discard  = 0;
            m_cnt      = 0;
            stall_prev = 0;
        end else if (armed) begin
            act = {out_data, out_sop, out_eop, out_empty};
            if (stall_prev) check_bits("stall_hold", 192'({out_valid, act}), 192'({1'b1, stall_beat}));
            stall_prev = out_valid && !out_ready;
            stall_beat = act;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    check_bits("out_beat", 192'(act), 192'(e));
                end
            end
            if (in_valid && in_ready) model_accept({in_data, in_sop, in_eop, in_empty});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit s, input bit e, input logic [EW-1:0] emp,
                        output int waits);
        bit got;
        got      = 0;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_empty = emp;
        while (!got && waits < 500) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else waits++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no ready expected ready within 500 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int w;
        int w3;
        int w4;
        int len;
        int guard;
        bit s;
        bit e;
        logic [DW-1:0] d22;
        d22 = {NB{8'h22}};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_bits("reset_out_valid", 192'(out_valid), 192'(0));
        check_bits("reset_in_ready", 192'(in_ready), 192'(1));
        check_bits("reset_out_data", 192'({out_data, out_sop, out_eop, out_empty}), 192'(0));

        // 1: clean 4-beat packet, 1-cycle latency
        send(128'h1111, 1, 0, 4'd7, w);
        check_bits("t1_latency_valid", 192'(out_valid), 192'(1));
        check_bits("t1_latency_data", 192'(out_data), 192'(128'h1111));
        send(128'h2222, 0, 0, 4'd5, w);
        send(128'h3333, 0, 0, 4'd0, w);
        send(128'h4444, 0, 1, 4'd3, w);
        idle(3);

        // 2: orphan beat then a clean packet
        send(d22, 0, 0, 4'd0, w);
        check_bits("t2_missing_pulse", 192'(err_missing), 192'(1));
        check_bits("t2_no_output", 192'(out_valid), 192'(0));
        send(128'h5501, 1, 0, 4'd0, w);
        send(128'h5502, 0, 1, 4'd2, w);
        idle(3);

        // 3: double SOP with filler insertion
        send(128'hA0, 1, 0, 4'd0, w);
        send(128'hA1, 0, 0, 4'd0, w);
        send(128'hB0, 1, 0, 4'd0, w3);
        send(128'hB1, 0, 1, 4'd9, w4);
        check_bits("t3_dsop_wait", 192'(w3), 192'(0));
        check_bits("t3_ready_drop_1cyc", 192'(w4), 192'(1));
        idle(3);

        // 4: oversize packet (6 beats, max 4) then clean packet
        for (int i = 0; i < 6; i++) send(128'(32'hC0 + i), i == 0, i == 5, 4'd1, w);
        send(128'hD0, 1, 0, 4'd0, w);
        send(128'hD1, 0, 1, 4'd4, w);
        idle(3);

        // 5: random downstream backpressure
        ready_rand = 1;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 4; i++) send(rnd_data(), i == 0, i == 3, 4'($urandom), w);
        ready_rand = 0;
        idle(4);

        // 6: reset mid-packet
        send(128'hE0, 1, 0, 4'd0, w);
        in_valid = 1'b1;
        in_data  = 128'hE1;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check_bits("t6_valid_after_rst", 192'(out_valid), 192'(0));
        send(128'hF0, 1, 0, 4'd0, w);
        send(128'hF1, 0, 0, 4'd0, w);
        send(128'hF2, 0, 1, 4'd6, w);
        idle(3);

        // Random framing with injected violations and backpressure
        ready_rand = 1;
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                s = (i == 0) ^ ($urandom % 10 == 0);
                e = (i == len - 1) ^ ($urandom % 10 == 0);
                send(rnd_data(), s, e, 4'($urandom), w);
                if ($urandom % 4 == 0) idle(1);
            end
        end
        ready_rand = 0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        idle(3);
        check_bits("drain_empty", 192'(exp_q.size()), 192'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
